// File: rtl/hp_fifo.sv
// hp_fifo: host-to-parasite FIFO clocked on the falling edge of h_phi2, with word or block handshake.
// Optional sticky overrun flag (h_overrun / p_clr_overrun) is built when HP_FIFO_OVERRUN_EN is defined.
module hp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             h_phi2,
    input  logic             h_rst_b,
    input  logic             h_we_b,
    input  logic             h_selectData,
    input  logic [WIDTH-1:0] h_data,
    input  logic             p_selectData,
    input  logic             p_rdnw,
    input  logic             p_block_mode,
    output logic [WIDTH-1:0] p_data,
    output logic             p_data_available,
    output logic             h_full,
    output logic [CW-1:0]    p_count
`ifdef HP_FIFO_OVERRUN_EN
    ,
    output logic             h_overrun,
    input  logic             p_clr_overrun
`endif
);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    // A single entry makes both handshakes identical, so block mode collapses onto word mode.
    localparam bit            BLOCK_OK   = (DEPTH > 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    logic [CW-1:0]    count, count_nxt;
    logic             wr, rd, wr_ok, rd_ok, block;

    assign wr      = h_selectData & ~h_we_b;
    assign rd      = p_selectData & p_rdnw;
    assign block   = p_block_mode & BLOCK_OK;
    assign p_data  = mem[head];
    assign p_count = count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
    always_comb begin
        h_full           = (count == FULL_COUNT);
        p_data_available = (count != '0);
        if (block) begin
            h_full           = (state == DRAIN);
            p_data_available = (state == DRAIN);
        end

        wr_ok     = wr & ~h_full;
        rd_ok     = rd & p_data_available;
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - 1'b1;
        end

        // Word mode keeps the state tracking occupancy so a later switch to block mode is coherent.
        state_nxt = (count_nxt != '0) ? DRAIN : FILL;
        if (block) begin
            state_nxt = state;
            if (state == FILL && count_nxt == FULL_COUNT) begin
                state_nxt = DRAIN;
            end else if (state == DRAIN && count_nxt == '0) begin
                state_nxt = FILL;
            end
        end
    end

    // NOTE: storage sits in the reset domain on purpose: p_data must read 0 during and after reset.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state <= FILL;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values, which a same-edge read and write rely on.
            state <= state_nxt;
            count <= count_nxt;
            if (wr_ok) begin
                mem[tail] <= h_data;
                tail      <= ptr_inc(tail);
            end
            if (rd_ok) begin
                head <= ptr_inc(head);
            end
        end
    end

`ifdef HP_FIFO_OVERRUN_EN
    // Set has priority over clear so a dropped write is never lost.
    always_ff @(negedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            h_overrun <= 1'b0;
        end else if (wr && h_full) begin
            h_overrun <= 1'b1;
        end else if (p_clr_overrun) begin
            h_overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/hp_fifo.md
HP_FIFO -- requirements
Module: hp_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the number of entries (legal range 1..32, any value).
REQ-003 SHALL define CW = clog2(DEPTH+1), meaning the occupancy count width.
REQ-004 SHALL have port h_phi2, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-005 SHALL have port h_rst_b, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port h_we_b, input, 1 bit: host write strobe, active-low.
REQ-007 SHALL have port h_selectData, input, 1 bit: host data register select.
REQ-008 SHALL have port h_data, input, WIDTH bits: host write data.
REQ-009 SHALL have port p_selectData, input, 1 bit: parasite data register select.
REQ-010 SHALL have port p_rdnw, input, 1 bit: parasite read (1) / write (0).
REQ-011 SHALL have port p_block_mode, input, 1 bit: 0 = word mode, 1 = block mode.
REQ-012 SHALL have port p_data, output, WIDTH bits: head-of-FIFO word.
REQ-013 SHALL have port p_data_available, output, 1 bit: parasite may read.
REQ-014 SHALL have port h_full, output, 1 bit: host must not write.
REQ-015 SHALL have port p_count, output, CW bits: current occupancy.

Function
REQ-016 SHALL define write request wr = h_selectData & !h_we_b and read request rd = p_selectData & p_rdnw, both sampled at the falling edge of h_phi2.
REQ-017 SHALL accept a write only when wr=1 and h_full=0; the word is stored at the tail pointer, and the tail pointer and count advance at that edge.
REQ-018 SHALL accept a read only when rd=1 and p_data_available=0 is false (i.e. p_data_available=1); the head pointer advances and count decrements at that edge.
REQ-019 SHALL drop a write issued while h_full=1 and a read issued while p_data_available=0, with no change to state.
REQ-020 SHALL, when a read and a write are accepted at the same edge, leave count unchanged and advance both pointers.
REQ-021 SHALL evaluate a simultaneous read and write using the flags from before the edge; a write while full is dropped even if a read frees an entry at that edge.
REQ-022 SHALL wrap the head and tail pointers from DEPTH-1 to 0.
REQ-023 SHALL drive p_data from the head entry combinationally; p_data is valid whenever p_data_available=1, and a written word appears on p_data one edge after the write when the FIFO was empty.
REQ-024 SHALL, in word mode, set h_full = (count==DEPTH) and p_data_available = (count!=0).
REQ-025 SHALL, in block mode, use a state machine with two states, FILL and DRAIN.
REQ-026 SHALL, in FILL, drive h_full=0 and p_data_available=0.
REQ-027 SHALL, in DRAIN, drive h_full=1 and p_data_available=1.
REQ-028 SHALL transition FILL->DRAIN at the edge where count becomes DEPTH.
REQ-029 SHALL transition DRAIN->FILL at the edge where count becomes 0.
REQ-030 SHALL, in word mode, update the state every edge to DRAIN if the next count is nonzero, else FILL, so that a mode switch is coherent.
REQ-031 SHALL, with DEPTH=1, make block mode behave identically to word mode.

Reset
REQ-032 SHALL, on h_rst_b low, immediately clear count, both pointers and all storage to 0 and set the state to FILL, regardless of any transfer in progress.
REQ-033 SHALL drive the following outputs during and after reset: p_data=0, p_count=0, p_data_available=0, h_full=0.

Configuration
REQ-034 SHALL, when HP_FIFO_OVERRUN_EN is defined, add output h_overrun (1 bit) and input p_clr_overrun (1 bit).
REQ-035 SHALL, with HP_FIFO_OVERRUN_EN defined, set h_overrun at the edge where a write is dropped, and hold it until p_clr_overrun=1 at an edge or reset; a set and a clear at the same edge leave it set.
REQ-036 SHALL, when HP_FIFO_OVERRUN_EN is not defined, omit both ports, with all other behaviour unchanged.

Verification
REQ-037 SHALL cover word mode with DEPTH=2: write 0xA5 then 0x3C, read twice -> p_data returns 0xA5 then 0x3C; h_full=1 after the second write; p_data_available=0 after the second read.
REQ-038 SHALL cover a full FIFO with DEPTH=2: a write of 0xFF while full -> the write is dropped, p_count stays 2, h_overrun=1 (macro on), and p_clr_overrun clears it.
REQ-039 SHALL cover block mode with DEPTH=4: three writes -> p_data_available=0; the fourth write -> DRAIN state with h_full=1; three reads -> h_full still 1; the fourth read -> FILL state with h_full=0.
REQ-040 SHALL cover simultaneous read and write with DEPTH=3: with count=1, write and read at the same edge -> count stays 1 and pointers wrap correctly over 10 iterations.
REQ-041 SHALL cover reset mid-operation: assert h_rst_b with count=2 in DRAIN -> all outputs go to 0 immediately, and the next write/read sequence works from empty.
